bcd_stopwatch_core: RTL and testbench



---
 rtl/bcd_stopwatch_core.sv | 200 ++++++++++++++++++++
 tb/tb_bcd_stopwatch_core.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch_core.sv
// ---------------------------------------------------------------------------
// bcd_stopwatch_core
//
// Four-digit BCD stopwatch for a multiplexed seven-segment display. Two raw
// pushbuttons are synchronised, debounced and turned into single-cycle press
// events. Those events drive an IDLE / RUN / PAUSE state machine. While the
// machine is in RUN, a prescaler produces one count tick every TICK_DIV
// cycles, and each tick advances the 0000-9999 BCD counter.
//
// Parameters
//   TICK_DIV  clk cycles per count increment (>= 2)
//   DEBOUNCE  consecutive stable cycles needed to accept a button change (>= 1)
//
// Ports
//   clk             system clock
//   rst_n           asynchronous, active-low reset
//   btn_start_stop  raw start/stop pushbutton, active-high, asynchronous
//   btn_clear       raw clear pushbutton, active-high, asynchronous
//   digit0..digit3  BCD ones / tens / hundreds / thousands
//   running         high while the machine is in RUN
//   carry_out       one-cycle pulse on the 9999 -> 0000 wrap
//   overflow        sticky wrap flag, cleared by clear press or reset
// ---------------------------------------------------------------------------
module bcd_stopwatch_core #(
    parameter int TICK_DIV = 100000000,
    parameter int DEBOUNCE = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic       running,
    output logic       carry_out,
    output logic       overflow
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Index 0 is start/stop and index 1 is clear, for both raw and press.
    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {btn_clear, btn_start_stop};

    // -----------------------------------------------------------------------
    // Per-button path: two-flop synchroniser, then the debounce filter, then
    // rising-edge detection on the debounced level.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic          s1_reg;
            logic          s2_reg;
            logic          stable_reg;
            logic          stable_d_reg;
            logic [DW-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_reg       <= 1'b0;
                    s2_reg       <= 1'b0;
                    stable_reg   <= 1'b0;
                    stable_d_reg <= 1'b0;
                    cnt_reg      <= '0;
                end else begin
                    s1_reg       <= btn_raw[gi];
                    s2_reg       <= s1_reg;
                    stable_d_reg <= stable_reg;
                    // cnt_reg counts consecutive cycles in which the
                    // synchronised level disagrees with the accepted level.
                    // Any agreeing cycle restarts the count, so short glitches
                    // never reach the acceptance threshold.
                    if (s2_reg == stable_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DW'(DEBOUNCE - 1)) begin
                        stable_reg <= s2_reg;
                        cnt_reg    <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + DW'(1);
                    end
                end
            end

            // Goes high only for an accepted 0 -> 1 change. A release
            // produces no event.
            assign press[gi] = stable_reg & ~stable_d_reg;
        end
    endgenerate

    logic press_start_stop;
    logic press_clear;

    assign press_start_stop = press[0];
    assign press_clear      = press[1];

    // -----------------------------------------------------------------------
    // Prescaler tick and BCD increment chain
    // -----------------------------------------------------------------------
    state_t          state_reg;
    state_t          state_next;
    logic [PW-1:0]   prescaler_reg;
    logic [3:0][3:0] digit_reg;
    logic [3:0][3:0] digit_next;
    logic [4:0]      inc_en;
    logic            tick;
    logic            wrap;
    logic            running_reg;
    logic            carry_reg;
    logic            overflow_reg;

    assign tick      = (state_reg == RUN) && (prescaler_reg == PW'(TICK_DIV - 1));
    assign inc_en[0] = tick;

    // A digit advances when the tick has rippled through every lower digit
    // that reads 9. All digits are computed from the same cycle's values and
    // update together, so no transient 10-15 code can ever appear.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign inc_en[gi+1]   = inc_en[gi] & (digit_reg[gi] == 4'd9);
            assign digit_next[gi] = !inc_en[gi]             ? digit_reg[gi] :
                                    (digit_reg[gi] == 4'd9) ? 4'd0 :
                                                              digit_reg[gi] + 4'd1;
        end
    endgenerate

    // The carry leaves the thousands digit only on 9999 -> 0000.
    assign wrap = inc_en[4];

    // -----------------------------------------------------------------------
    // Start/stop transitions. The clear press has priority over these and is
    // handled in the register block below.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (press_start_stop) begin
            unique case (state_reg)
                IDLE:    state_next = RUN;
                RUN:     state_next = PAUSE;
                PAUSE:   state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State, prescaler, digits and the registered flags
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            running_reg   <= 1'b0;
            prescaler_reg <= '0;
            digit_reg     <= '0;
            carry_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
        end else if (press_clear) begin
            state_reg     <= IDLE;
            running_reg   <= 1'b0;
            prescaler_reg <= '0;
            digit_reg     <= '0;
            carry_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            running_reg <= (state_next == RUN);
            // The tick depends only on the current state. A pause press that
            // lands on a tick cycle therefore still applies that tick.
            digit_reg   <= digit_next;
            carry_reg   <= wrap;
            if (wrap) begin
                overflow_reg <= 1'b1;
            end
            // In PAUSE the prescaler holds its value, so a resume continues
            // from the same phase instead of restarting the interval.
            if (state_reg == RUN) begin
                prescaler_reg <= tick ? '0 : prescaler_reg + PW'(1);
            end
        end
    end

    assign digit0    = digit_reg[0];
    assign digit1    = digit_reg[1];
    assign digit2    = digit_reg[2];
    assign digit3    = digit_reg[3];
    assign running   = running_reg;
    assign carry_out = carry_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
module tb_bcd_stopwatch_core;

    localparam int TD = 4;
    localparam int D  = 3;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_ss = 1'b0;
    logic       btn_clr = 1'b0;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic       running, carry_out, overflow;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_stopwatch_core #(.TICK_DIV(TD), .DEBOUNCE(D)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .btn_start_stop (btn_ss),
        .btn_clear      (btn_clr),
        .digit0         (digit0),
        .digit1         (digit1),
        .digit2         (digit2),
        .digit3         (digit3),
        .running        (running),
        .carry_out      (carry_out),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    wire [15:0] dut_digits = {digit3, digit2, digit1, digit0};

    function automatic logic [15:0] bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // ---------------- behavioural model ----------------
    // The count is held as a plain integer, and the display digits are
    // derived from it with division. A debounced level flips once the last
    // D synchronised samples all disagree with it.
    bit [1:0]   m_s1, m_s2, m_stab, m_stab_d;
    bit [D-1:0] m_hist [2];
    int         m_state, m_count, m_phase;
    bit         m_carry, m_ovf;

    wire [1:0] m_press = m_stab & ~m_stab_d;
    wire       m_tick  = (m_state == M_RUN) && (m_phase == TD - 1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 <= '0; m_s2 <= '0; m_stab <= '0; m_stab_d <= '0;
            m_hist[0] <= '0; m_hist[1] <= '0;
            m_state <= M_IDLE; m_count <= 0; m_phase <= 0;
            m_carry <= 1'b0; m_ovf <= 1'b0;
        end else begin
            m_s1     <= {btn_clr, btn_ss};
            m_s2     <= m_s1;
            m_stab_d <= m_stab;
            for (int b = 0; b < 2; b++) begin
                m_hist[b] <= {m_hist[b][D-2:0], m_s2[b]};
                if ({m_hist[b][D-2:0], m_s2[b]} == {D{~m_stab[b]}})
                    m_stab[b] <= ~m_stab[b];
            end
            if (m_press[1]) begin
                m_state <= M_IDLE; m_count <= 0; m_phase <= 0;
                m_carry <= 1'b0; m_ovf <= 1'b0;
            end else begin
                m_carry <= m_tick && (m_count == 9999);
                if (m_tick) begin
                    m_count <= (m_count + 1) % 10000;
                    if (m_count == 9999) m_ovf <= 1'b1;
                end
                if (m_state == M_RUN) m_phase <= (m_phase + 1) % TD;
                if (m_press[0]) m_state <= (m_state == M_RUN) ? M_PAUSE : M_RUN;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic lit(input string name, input int act, input int exp);
        chk(name, act, exp);
        $display("[TB] check %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model_digits",   dut_digits, bcd(m_count));
        chk("model_running",  running,    (m_state == M_RUN) ? 1 : 0);
        chk("model_carry",    carry_out,  m_carry);
        chk("model_overflow", overflow,   m_ovf);
    end

    task automatic step_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    logic [15:0] prev;
    bit          found;

    initial begin
        step_n(2);
        lit("reset_digits", dut_digits, 16'h0000);
        lit("reset_running", running, 0);
        rst_n = 1'b1;
        step_n(2);

        // Start: the press must be visible after edge 6, not before.
        btn_ss = 1'b1;
        step_n(5);
        lit("start_not_yet", running, 0);
        step_n(1);
        lit("start_edge6", running, 1);
        step_n(4);
        btn_ss = 1'b0;
        step_n(36);
        lit("count_40_cycles", dut_digits, 16'h0010);

        // A two-cycle glitch is shorter than the debounce window.
        btn_ss = 1'b1;
        step_n(2);
        btn_ss = 1'b0;
        step_n(10);
        lit("glitch_ignored", running, 1);

        // Clear
        btn_clr = 1'b1;
        step_n(6);
        lit("clear_running", running, 0);
        lit("clear_digits", dut_digits, 16'h0000);
        btn_clr = 1'b0;
        step_n(8);

        // Pause at prescaler 2 with 0005, then resume
        btn_ss = 1'b1;
        step_n(6);
        lit("run_again", running, 1);
        btn_ss = 1'b0;
        step_n(16);
        btn_ss = 1'b1;
        step_n(6);
        lit("paused", running, 0);
        lit("pause_digits", dut_digits, 16'h0005);
        btn_ss = 1'b0;
        step_n(20);
        lit("pause_hold", dut_digits, 16'h0005);
        btn_ss = 1'b1;
        step_n(6);
        lit("resumed", running, 1);
        btn_ss = 1'b0;
        step_n(1);
        lit("resume_plus1", dut_digits, 16'h0005);
        step_n(1);
        lit("resume_plus2", dut_digits, 16'h0006);

        // Wrap 9999 -> 0000
        found = 1'b0;
        prev  = dut_digits;
        for (int i = 0; i < 45000 && !found; i++) begin
            step_n(1);
            if (carry_out) found = 1'b1;
            else prev = dut_digits;
        end
        lit("wrap_seen", found, 1);
        if (found) begin
            lit("wrap_before", prev, 16'h9999);
            lit("wrap_digits", dut_digits, 16'h0000);
            lit("wrap_overflow", overflow, 1);
            step_n(1);
            lit("carry_one_cycle", carry_out, 0);
            step_n(8);
            lit("overflow_sticky", overflow, 1);
        end
        btn_clr = 1'b1;
        step_n(6);
        lit("clr_after_wrap_digits", dut_digits, 16'h0000);
        lit("clr_after_wrap_ovf", overflow, 0);
        lit("clr_after_wrap_running", running, 0);
        btn_clr = 1'b0;
        step_n(8);

        // Simultaneous presses: clear wins
        btn_ss = 1'b1;
        step_n(6);
        lit("sim_pre_run", running, 1);
        btn_ss = 1'b0;
        step_n(12);
        btn_ss = 1'b1;
        btn_clr = 1'b1;
        step_n(6);
        lit("sim_running", running, 0);
        lit("sim_digits", dut_digits, 16'h0000);
        btn_ss = 1'b0;
        btn_clr = 1'b0;
        step_n(8);
        btn_ss = 1'b1;
        step_n(6);
        lit("sim_then_start", running, 1);
        btn_ss = 1'b0;

        // Asynchronous reset at 0123
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            step_n(1);
            if (dut_digits == 16'h0123) found = 1'b1;
        end
        lit("reach_0123", found, 1);
        rst_n = 1'b0;
        #1;
        lit("async_rst_digits", dut_digits, 16'h0000);
        lit("async_rst_running", running, 0);
        lit("async_rst_overflow", overflow, 0);
        step_n(2);
        rst_n = 1'b1;
        step_n(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
